// File: rtl/shreg_defs.sv
// rtl/shreg_defs.sv - shared mode and state encodings for seq_shift_reg
package shreg_defs;

  typedef enum logic [2:0] {
    MODE_SLL  = 3'd0,
    MODE_SRL  = 3'd1,
    MODE_SRA  = 3'd2,
    MODE_ROL  = 3'd3,
    MODE_ROR  = 3'd4,
    MODE_SIL  = 3'd5,
    MODE_SIR  = 3'd6,
    MODE_RSVD = 3'd7
  } shift_mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } shreg_state_e;

endpackage

// File: rtl/shift_step.sv
// rtl/shift_step.sv - combinational single-step shifter/rotator
module shift_step
  import shreg_defs::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] value,
  input  logic [2:0]       mode,
  input  logic             serial_in,
  output logic [WIDTH-1:0] value_next,
  output logic             eject_bit
);

  always_comb begin
    value_next = value;
    eject_bit  = 1'b0;
    case (shift_mode_e'(mode))
      MODE_SLL: begin
        value_next = {value[WIDTH-2:0], 1'b0};
        eject_bit  = value[WIDTH-1];
      end
      MODE_SRL: begin
        value_next = {1'b0, value[WIDTH-1:1]};
        eject_bit  = value[0];
      end
      MODE_SRA: begin
        value_next = {value[WIDTH-1], value[WIDTH-1:1]};
        eject_bit  = value[0];
      end
      MODE_ROL: begin
        value_next = {value[WIDTH-2:0], value[WIDTH-1]};
        eject_bit  = value[WIDTH-1];
      end
      MODE_ROR: begin
        value_next = {value[0], value[WIDTH-1:1]};
        eject_bit  = value[0];
      end
      MODE_SIL: begin
        value_next = {value[WIDTH-2:0], serial_in};
        eject_bit  = value[WIDTH-1];
      end
      MODE_SIR: begin
        value_next = {serial_in, value[WIDTH-1:1]};
        eject_bit  = value[0];
      end
      default: begin
        // reserved mode: the step is counted but the data holds
        value_next = value;
        eject_bit  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/seq_shift_reg.sv
// rtl/seq_shift_reg.sv - operand register with parallel load and multi-cycle shift engine
module seq_shift_reg
  import shreg_defs::*;
#(
  parameter  int WIDTH = 8,
  localparam int AW    = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic [AW-1:0]    amount,
  input  logic             serial_in,
  output logic [WIDTH-1:0] data_out,
  output logic             serial_out,
  output logic             busy,
  output logic             done
);

  localparam logic [AW-1:0] CNT_LAST = AW'(1);

  shreg_state_e     state_q, state_d;
  shift_mode_e      mode_q, mode_d;
  logic [AW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             sout_q, sout_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] step_value;
  logic             step_bit;

  shift_step #(.WIDTH(WIDTH)) u_step (
    .value      (data_q),
    .mode       (mode_q),
    .serial_in  (serial_in),
    .value_next (step_value),
    .eject_bit  (step_bit)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_SLL;
      cnt_q   <= '0;
      data_q  <= '0;
      sout_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      sout_q  <= sout_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    sout_d  = sout_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (load) begin
          data_d = data_in;
        end else if (start) begin
          mode_d = shift_mode_e'(mode);
          if (amount != '0) begin
            cnt_d   = amount;
            state_d = ST_RUN;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        data_d = step_value;
        if (mode_q != MODE_RSVD) sout_d = step_bit;
        cnt_d = cnt_q - CNT_LAST;
        // completion is flagged on the edge that performs the final step
        if (cnt_q == CNT_LAST) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign data_out   = data_q;
  assign serial_out = sout_q;
  assign busy       = (state_q == ST_RUN);
  assign done       = done_q;

endmodule

// File: tb/tb_seq_shift_reg.sv
// tb/tb_seq_shift_reg.sv - self-checking bench for seq_shift_reg
module tb_seq_shift_reg;

  localparam int W  = 8;
  localparam int AW = $clog2(W) + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          load;
  logic [W-1:0]  data_in;
  logic          start;
  logic [2:0]    mode;
  logic [AW-1:0] amount;
  logic          serial_in;
  logic [W-1:0]  data_out;
  logic          serial_out;
  logic          busy;
  logic          done;

  int compared   = 0;
  int mismatched = 0;

  logic [W-1:0] m_data;
  logic         m_sout;

  seq_shift_reg #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .data_in    (data_in),
    .start      (start),
    .mode       (mode),
    .amount     (amount),
    .serial_in  (serial_in),
    .data_out   (data_out),
    .serial_out (serial_out),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference behaviour of one step, written as word arithmetic.
  task automatic model_step(input int m, input logic si);
    logic [W-1:0] v;
    v = m_data;
    case (m)
      0: begin m_sout = v[W-1]; m_data = v << 1; end
      1: begin m_sout = v[0];   m_data = v >> 1; end
      2: begin m_sout = v[0];   m_data = W'($signed(v) >>> 1); end
      3: begin m_sout = v[W-1]; m_data = (v << 1) | (v >> (W-1)); end
      4: begin m_sout = v[0];   m_data = (v >> 1) | (v << (W-1)); end
      5: begin m_sout = v[W-1]; m_data = (v << 1) | W'(si); end
      6: begin m_sout = v[0];   m_data = (v >> 1) | (W'(si) << (W-1)); end
      default: ;
    endcase
  endtask

  task automatic do_load(input logic [W-1:0] v);
    @(negedge clk);
    load = 1'b1; start = 1'b0; data_in = v;
    @(posedge clk); #1;
    m_data = v;
    chk("load_data", 32'(data_out), 32'(m_data));
    chk("load_sout", 32'(serial_out), 32'(m_sout));
    chk("load_busy", 32'(busy), 32'd0);
    @(negedge clk);
    load = 1'b0;
  endtask

  // si_fixed < 0 draws a fresh random serial_in for every step.
  task automatic run_op(input int m, input int n, input int si_fixed);
    logic si;
    @(negedge clk);
    load = 1'b0; start = 1'b1; mode = 3'(m); amount = AW'(n);
    @(posedge clk); #1;
    if (n == 0) begin
      chk("zero_done", 32'(done), 32'd1);
      chk("zero_busy", 32'(busy), 32'd0);
      chk("zero_data", 32'(data_out), 32'(m_data));
    end else begin
      chk("start_busy", 32'(busy), 32'd1);
      chk("start_done", 32'(done), 32'd0);
      for (int k = 1; k <= n; k++) begin
        @(negedge clk);
        // commands while busy must be ignored
        load    = 1'b1;
        data_in = 8'hFF;
        start   = 1'($urandom);
        mode    = 3'($urandom);
        amount  = AW'($urandom);
        si = (si_fixed < 0) ? 1'($urandom) : 1'(si_fixed);
        serial_in = si;
        @(posedge clk); #1;
        model_step(m, si);
        chk("step_data", 32'(data_out), 32'(m_data));
        chk("step_sout", 32'(serial_out), 32'(m_sout));
        chk("step_busy", 32'(busy), 32'(k < n));
        chk("step_done", 32'(done), 32'(k == n));
      end
    end
    @(negedge clk);
    load = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    chk("after_done", 32'(done), 32'd0);
    chk("after_busy", 32'(busy), 32'd0);
    chk("after_data", 32'(data_out), 32'(m_data));
  endtask

  initial begin
    reset = 1'b1; load = 1'b0; data_in = '0; start = 1'b0;
    mode = '0; amount = '0; serial_in = 1'b0;
    m_data = '0; m_sout = 1'b0;
    @(posedge clk); #1;
    chk("rst_data", 32'(data_out), 32'd0);
    chk("rst_sout", 32'(serial_out), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    do_load(8'h81);
    run_op(0, 3, -1);
    chk("tp1_final", 32'(data_out), 32'h08);
    chk("tp1_sout", 32'(serial_out), 32'd0);

    do_load(8'h81);
    run_op(2, 2, -1);
    chk("tp2_final", 32'(data_out), 32'hE0);

    do_load(8'h81);
    run_op(4, 9, -1);
    chk("tp3_final", 32'(data_out), 32'hC0);
    chk("tp3_sout", 32'(serial_out), 32'd1);

    do_load(8'h00);
    run_op(5, 4, 1);
    chk("tp4_final", 32'(data_out), 32'h0F);

    do_load(8'h5A);
    run_op(1, 0, -1);
    chk("zero_keep", 32'(data_out), 32'h5A);

    // load and start together: load wins, no shift starts
    @(negedge clk);
    load = 1'b1; start = 1'b1; mode = 3'd0; amount = AW'(3); data_in = 8'h3C;
    @(posedge clk); #1;
    m_data = 8'h3C;
    chk("ls_data", 32'(data_out), 32'h3C);
    chk("ls_busy", 32'(busy), 32'd0);
    @(negedge clk);
    load = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    chk("ls_busy2", 32'(busy), 32'd0);
    chk("ls_done2", 32'(done), 32'd0);

    // reset during step 2 of an 8-step rotate
    do_load(8'hA5);
    @(negedge clk);
    start = 1'b1; mode = 3'd3; amount = AW'(8);
    @(posedge clk); #1;
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk);
      start = 1'b0;
      @(posedge clk); #1;
      model_step(3, 1'b0);
      chk("rr_step", 32'(data_out), 32'(m_data));
    end
    #2 reset = 1'b1;
    #1;
    m_data = '0; m_sout = 1'b0;
    chk("rr_data", 32'(data_out), 32'd0);
    chk("rr_sout", 32'(serial_out), 32'd0);
    chk("rr_busy", 32'(busy), 32'd0);
    chk("rr_done", 32'(done), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      chk("rr_nodone", 32'(done), 32'd0);
      chk("rr_idle", 32'(busy), 32'd0);
    end
    do_load(8'hC3);
    run_op(3, 8, -1);
    chk("rr_rerun", 32'(data_out), 32'hC3);

    // randomized commands against the reference model
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0)
        do_load(W'($urandom));
      else
        run_op(int'($urandom_range(0, 7)), int'($urandom_range(0, 15)), -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/seq_shift_reg.md
# seq_shift_reg

Parametrised sequential shift register, the successor to the 8-bit load register. Adds a multi-cycle shift/rotate engine with a start/busy/done handshake, serial in/out and a selectable shift mode. Parallel load is kept as before. It sits in the datapath as a general-purpose operand register for shifter and serial-conversion tasks.

## Interface
- WIDTH, 8: register width in bits, ≥2
- AW, $clog2(WIDTH)+1: width of the shift amount field (local, derived)
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- load  input  1  parallel load request, honoured in IDLE only
- data_in  input  WIDTH  parallel load value
- start  input  1  begin a shift operation, honoured in IDLE only
- mode  input  3  shift mode, sampled with start
- amount  input  AW  number of 1-bit steps, sampled with start
- serial_in  input  1  fill bit for serial modes, sampled at every step
- data_out  output  WIDTH  register contents
- serial_out  output  1  bit ejected by the most recent step
- busy  output  1  shift operation in progress
- done  output  1  one-cycle completion pulse

## Operation
- Reset values: data_out=0, serial_out=0, busy=0, done=0, state=IDLE, step counter=0.
- Reset asserted mid-operation aborts the shift immediately. The register returns to the reset values and no done pulse is produced.
- States:
  - IDLE:
    - load=1: data_out←data_in at the next edge; serial_out unchanged.
    - Else start=1: latch mode and amount.
      - amount≠0 → RUN.
      - amount=0 → stay IDLE and pulse done next cycle; data unchanged.
    - load has priority over start when both are high.
  - RUN: one 1-bit step per clock; the counter decrements on each step. After the last step → IDLE.
- Step per mode:
  - 0 SLL: shift left, LSB←0.
  - 1 SRL: shift right, MSB←0.
  - 2 SRA: shift right, MSB←old MSB.
  - 3 ROL: rotate left.
  - 4 ROR: rotate right.
  - 5 SIL: shift left, LSB←serial_in.
  - 6 SIR: shift right, MSB←serial_in.
  - 7 reserved: steps are counted, data and serial_out unchanged.
- serial_out per step:
  - Left modes: old MSB.
  - Right modes: old LSB.
  - Rotates: the bit that wrapped.
- No clamping of amount: exactly amount steps are performed. Amounts ≥WIDTH on shifts give all-fill; on rotates they wrap naturally.
- While busy: load, start, mode and amount are ignored. A start in the same cycle as done is not honoured, because the FSM is still leaving RUN.

## Timing
- start sampled at edge E0 with amount=N>0:
  - busy=1 from E0 to EN.
  - Steps occur at edges E1..EN.
  - busy falls and done rises at EN.
  - done falls at EN+1.
- amount=0: done high for one cycle after E0; busy stays 0.
- load latency: 1 cycle.
- Earliest accepted new command after completion: the edge following EN.
- All outputs are registered; there are no combinational input-to-output paths.

## Structure
- Shared definitions header/package shreg_defs:
  - Mode encodings MODE_SLL..MODE_SIR and MODE_RSVD.
  - FSM state encodings ST_IDLE and ST_RUN.
- Sub-module shift_step: purely combinational single-step shifter.
  - Inputs: value, mode, serial_in.
  - Outputs: next value, ejected bit.
  - Instantiated once in seq_shift_reg; the top level holds the FSM, counter and registers.

## Test plan
1. Load then SLL: load 0x81, then start mode=0, amount=3 → data 0x02, 0x04, 0x08 on successive edges; busy high 3 cycles; single done pulse; serial_out=0.
2. SRA: load 0x81, then mode=2, amount=2 → 0xC0 then 0xE0; serial_out=1 then 0.
3. ROR with amount>WIDTH: load 0x81, then mode=4, amount=9 → final data 0xC0; busy 9 cycles; serial_out=1 after the last step.
4. SIL: load 0x00, then mode=5, amount=4, serial_in=1 → data 0x0F; done pulses once.
5. Corner commands:
   - amount=0 → done pulse, busy never high, data unchanged.
   - load=1 with data_in=0xFF while busy → ignored.
   - load and start high together in IDLE → load wins.
6. Reset at step 2 of an 8-step ROL → outputs 0 immediately; no done pulse; the next start after reset release runs normally.
